// File: rtl/seg7_pkg.sv
// Shared constants and FSM state type for the six-digit 7-segment number formatter.
package seg7_pkg;
   localparam int NDIG = 6;
   localparam logic [3:0] DIG_BLANK = 4'hE;
   localparam logic [3:0] DIG_MINUS = 4'hF;
   localparam logic [2:0] DP_NONE = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_FORMAT,
      ST_DONE
   } seg7State_t;
endpackage

// File: rtl/seg7_fmt_place.sv
// Combinational digit placement: blanking, minus sign, dot and overflow pattern
// applied to five BCD digits.
module seg7_fmt_place
   import seg7_pkg::*;
(
   input  logic [4*(NDIG-1)-1:0] bcd,
   input  logic                  neg,
   input  logic                  ovf,
   input  logic [2:0]            dp,
   output logic [4*NDIG-1:0]     dig,
   output logic [NDIG-1:0]       dot
);

   logic [2:0] msd;
   logic [2:0] keep;
   logic       dotEn;

   always_comb begin
      msd   = 3'd0;
      dotEn = (dp < DP_NONE);
      dig   = {NDIG{DIG_BLANK}};
      dot   = '0;
      for (int k = 0; k < NDIG-1; k++) begin
         if (bcd[4*k +: 4] != 4'd0) msd = 3'(k);
      end
      // A dot left of the leading digit forces the zeros up to it to be shown.
      keep = (dotEn && (dp > msd)) ? dp : msd;
      if (ovf) begin
         dig = {NDIG{DIG_MINUS}};
      end else begin
         for (int k = 0; k < NDIG-1; k++) begin
            if (3'(k) <= keep) dig[4*k +: 4] = bcd[4*k +: 4];
         end
         for (int k = 0; k < NDIG; k++) begin
            if (neg && (3'(k) == keep + 3'd1)) dig[4*k +: 4] = DIG_MINUS;
         end
         if (dotEn) dot = NDIG'(1) << dp;
      end
   end

endmodule

// File: rtl/seg7_num_fmt.sv
// Signed binary to six-digit 7-segment code formatter using one double-dabble
// shift per clock; the formatted result is held until the next conversion.
module seg7_num_fmt
   import seg7_pkg::*;
#(
   parameter int W       = 20,
   parameter int MAX_MAG = 99999
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic                iSTART,
   input  logic signed [W-1:0] iVALUE,
   input  logic [2:0]          iDP_POS,
   output logic                oBUSY,
   output logic                oDONE,
   output logic [4*NDIG-1:0]   oDIG,
   output logic [NDIG-1:0]     oDOT,
   output logic                oOVF
);

   localparam int CNT_W = $clog2(W+1);
   localparam logic [W:0] MAX_MAG_V = (W+1)'(MAX_MAG);

   seg7State_t state, stateNext;

   logic signed [W-1:0]  valueQ;
   logic [2:0]           dpQ;
   logic                 negQ;
   logic                 ovfQ;
   logic [W-1:0]         magQ;
   logic [4*NDIG-1:0]    bcdQ;
   logic [CNT_W-1:0]     cntQ;
   logic signed [W:0]    valueExt;
   logic [W:0]           magFull;
   logic [4*NDIG-1:0]    placeDig;
   logic [NDIG-1:0]      placeDot;

   function automatic logic [4*NDIG-1:0] dabbleAdjust(input logic [4*NDIG-1:0] b);
      logic [4*NDIG-1:0] r;
      r = b;
      for (int k = 0; k < NDIG; k++) begin
         if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

   // One extra bit so that the most negative input still has a positive magnitude.
   assign valueExt = {valueQ[W-1], valueQ};
   assign magFull  = unsigned'(valueQ[W-1] ? -valueExt : valueExt);

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:   if (iSTART) stateNext = ST_LOAD;
         ST_LOAD:   stateNext = ST_SHIFT;
         ST_SHIFT:  if (cntQ == CNT_W'(1)) stateNext = ST_FORMAT;
         ST_FORMAT: stateNext = ST_DONE;
         ST_DONE:   stateNext = ST_IDLE;
         default:   stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state <= ST_IDLE;
         cntQ  <= '0;
         oBUSY <= 1'b0;
         oDONE <= 1'b0;
         oDIG  <= {NDIG{DIG_BLANK}};
         oDOT  <= '0;
         oOVF  <= 1'b0;
      end else begin
         state <= stateNext;
         oBUSY <= (stateNext != ST_IDLE);
         oDONE <= (stateNext == ST_DONE);
         if (state == ST_LOAD) cntQ <= CNT_W'(W);
         else if (state == ST_SHIFT) cntQ <= cntQ - CNT_W'(1);
         if (state == ST_FORMAT) begin
            oDIG <= placeDig;
            oDOT <= placeDot;
            oOVF <= ovfQ;
         end
      end
   end

   // Datapath registers carry no reset; the FSM decides when they are meaningful.
   always_ff @(posedge iCLK) begin
      case (state)
         ST_IDLE: begin
            if (iSTART) begin
               valueQ <= iVALUE;
               dpQ    <= iDP_POS;
            end
         end
         ST_LOAD: begin
            negQ <= valueQ[W-1];
            ovfQ <= (magFull > MAX_MAG_V);
            magQ <= magFull[W-1:0];
            bcdQ <= '0;
         end
         ST_SHIFT: {bcdQ, magQ} <= {dabbleAdjust(bcdQ), magQ} << 1;
         default: ;
      endcase
   end

   seg7_fmt_place uPlace (
      .bcd (bcdQ[4*(NDIG-1)-1:0]),
      .neg (negQ),
      .ovf (ovfQ),
      .dp  (dpQ),
      .dig (placeDig),
      .dot (placeDot)
   );

endmodule

// File: tb/tb_seg7_num_fmt.sv
// Directed scoreboard bench for seg7_num_fmt.
module tb_seg7_num_fmt;
   localparam int W = 20;

   logic                iCLK = 1'b0;
   logic                iRST;
   logic                iSTART;
   logic signed [W-1:0] iVALUE;
   logic [2:0]          iDP_POS;
   logic                oBUSY;
   logic                oDONE;
   logic [23:0]         oDIG;
   logic [5:0]          oDOT;
   logic                oOVF;

   int checks = 0;
   int errors = 0;
   int doneCount = 0;
   int prevDone;

   typedef struct packed {
      logic [23:0] dig;
      logic [5:0]  dot;
      logic        ovf;
   } exp_t;

   exp_t sb[$];

   seg7_num_fmt #(.W(W), .MAX_MAG(99999)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iSTART  (iSTART),
      .iVALUE  (iVALUE),
      .iDP_POS (iDP_POS),
      .oBUSY   (oBUSY),
      .oDONE   (oDONE),
      .oDIG    (oDIG),
      .oDOT    (oDOT),
      .oOVF    (oOVF)
   );

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) if (oDONE === 1'b1) doneCount++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic runConv(input logic signed [W-1:0] v, input logic [2:0] dp,
                          input logic [23:0] eDig, input logic [5:0] eDot,
                          input logic eOvf, input int injectAt);
      exp_t        e;
      int          lat;
      logic        windowOk;
      logic [23:0] prevDig;
      sb.push_back('{eDig, eDot, eOvf});
      @(negedge iCLK);
      prevDig = oDIG;
      iSTART  = 1'b1;
      iVALUE  = v;
      iDP_POS = dp;
      @(negedge iCLK);
      iSTART   = 1'b0;
      iVALUE   = W'($urandom);
      iDP_POS  = 3'($urandom);
      lat      = 1;
      windowOk = 1'b1;
      while (oDONE !== 1'b1 && lat < 40) begin
         if (oBUSY !== 1'b1 || oDIG !== prevDig) windowOk = 1'b0;
         if (lat == injectAt) begin
            iSTART = 1'b1;
            iVALUE = W'(1);
         end else begin
            iSTART = 1'b0;
         end
         @(negedge iCLK);
         lat++;
      end
      iSTART = 1'b0;
      check("busy_window", 32'(windowOk), 32'd1);
      check("done_seen", 32'(oDONE), 32'd1);
      check("latency", lat, 32'd23);
      check("busy_at_done", 32'(oBUSY), 32'd1);
      e = sb.pop_front();
      check("dig", 32'(oDIG), 32'(e.dig));
      check("dot", 32'(oDOT), 32'(e.dot));
      check("ovf", 32'(oOVF), 32'(e.ovf));
      @(negedge iCLK);
      check("done_pulse", 32'(oDONE), 32'd0);
      check("busy_idle", 32'(oBUSY), 32'd0);
      check("dig_hold", 32'(oDIG), 32'(e.dig));
   endtask

   initial begin
      iRST    = 1'b1;
      iSTART  = 1'b0;
      iVALUE  = '0;
      iDP_POS = 3'd0;
      repeat (3) @(negedge iCLK);
      check("rst_dig", 32'(oDIG), 32'hEEEEEE);
      check("rst_dot", 32'(oDOT), 32'd0);
      check("rst_ovf", 32'(oOVF), 32'd0);
      check("rst_busy", 32'(oBUSY), 32'd0);
      check("rst_done", 32'(oDONE), 32'd0);
      iRST = 1'b0;

      runConv(W'(12345),   3'd7, 24'hE12345, 6'b000000, 1'b0, 0);
      runConv(W'(-42),     3'd7, 24'hEEEF42, 6'b000000, 1'b0, 0);
      runConv(W'(7),       3'd2, 24'hEEE007, 6'b000100, 1'b0, 0);
      runConv(W'(-7),      3'd2, 24'hEEF007, 6'b000100, 1'b0, 0);
      runConv(W'(-99999),  3'd7, 24'hF99999, 6'b000000, 1'b0, 0);
      runConv(W'(99999),   3'd7, 24'hE99999, 6'b000000, 1'b0, 0);
      runConv(W'(100000),  3'd7, 24'hFFFFFF, 6'b000000, 1'b1, 0);
      runConv(W'(-524288), 3'd3, 24'hFFFFFF, 6'b000000, 1'b1, 0);
      runConv(W'(0),       3'd7, 24'hEEEEE0, 6'b000000, 1'b0, 0);
      runConv(W'(-5),      3'd0, 24'hEEEEF5, 6'b000001, 1'b0, 0);
      runConv(W'(123),     3'd4, 24'hE00123, 6'b010000, 1'b0, 0);
      runConv(W'(-123),    3'd4, 24'hF00123, 6'b010000, 1'b0, 0);

      prevDone = doneCount;
      runConv(W'(1000), 3'd5, 24'hEE1000, 6'b000000, 1'b0, 5);
      repeat (30) @(negedge iCLK);
      check("single_done", doneCount - prevDone, 32'd1);
      check("ignored_start_dig", 32'(oDIG), 32'hEE1000);

      prevDone = doneCount;
      @(negedge iCLK);
      iSTART  = 1'b1;
      iVALUE  = W'(777);
      iDP_POS = 3'd7;
      @(negedge iCLK);
      iSTART = 1'b0;
      repeat (8) @(negedge iCLK);
      iRST = 1'b1;
      #1;
      check("abort_dig", 32'(oDIG), 32'hEEEEEE);
      check("abort_dot", 32'(oDOT), 32'd0);
      check("abort_ovf", 32'(oOVF), 32'd0);
      check("abort_busy", 32'(oBUSY), 32'd0);
      check("abort_done", 32'(oDONE), 32'd0);
      @(negedge iCLK);
      iRST = 1'b0;
      repeat (30) @(negedge iCLK);
      check("abort_no_done", doneCount - prevDone, 32'd0);

      runConv(W'(5), 3'd7, 24'hEEEEE5, 6'b000000, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
